pwm_capture: RTL
================

# pwm_capture

Receive-side counterpart to the 40 kHz PWM transmit path. Synchronises an external square-wave input, such as a comparator-squared ultrasonic echo or a loopback of the transmit PWM. Per cycle of the input it measures the period and the high time in system clock cycles. It also reports frequency lock against the expected period, and flags loss of signal via timeout. It sits between the analog front-end comparator and the echo/time-of-flight logic.

## Interface
Parameters:
- PERIOD_IN_CLOCK_CYCLES, 2500, expected input period (40 kHz at 100 MHz).
- TOLERANCE, 125, max |measured − expected| period counted as a match.
- LOCK_COUNT, 4, consecutive matching periods required to assert lock.
- TIMEOUT_CYCLES, 5000, cycles without a rising edge before signal is declared lost.
- W, $clog2(TIMEOUT_CYCLES+1), measurement width (derived; do not override).

Ports:
- clk_in  input  1  system clock; the block's only clock.
- rst_n_in  input  1  reset, asynchronous, active-low.
- sig_in  input  1  asynchronous square-wave input.
- period_out  output  W  cycles between the last two rising edges.
- high_out  output  W  cycles from last-but-one rising edge to the following falling edge.
- meas_valid_out  output  1  one-cycle strobe; period_out/high_out updated this cycle.
- locked_out  output  1  LOCK_COUNT consecutive matching periods seen.
- timeout_out  output  1  one-cycle strobe on signal loss.

## Operation
- sig_in passes through a 2-FF synchronizer and then a previous-value register.
- rise = sync & ~prev; fall = ~sync & prev.
- Cycle counter cnt: loads 1 on rise, otherwise increments, saturating at TIMEOUT_CYCLES.
  - Edges P cycles apart therefore give cnt == P on the second rise.
- On fall in ARMED/TRACK: high_cap <= cnt.
- States:
  - IDLE: no reference edge yet. On rise → ARMED.
  - ARMED: first rise seen, counting. On rise with cnt < TIMEOUT_CYCLES → TRACK and emit a measurement.
  - TRACK: every rise with cnt < TIMEOUT_CYCLES emits a measurement and stays in TRACK.
- Emitting a measurement (all registered):
  - period_out <= cnt;
  - high_out <= high_cap;
  - meas_valid_out <= 1.
- Match test: |cnt − PERIOD_IN_CLOCK_CYCLES| <= TOLERANCE. Compute in W+1 bits signed; no wrap.
  - Match: match_cnt increments, saturating at LOCK_COUNT.
  - Mismatch: match_cnt clears to 0.
  - locked_out <= (next match_cnt == LOCK_COUNT).
- Timeout: in ARMED/TRACK, cnt == TIMEOUT_CYCLES and no rise that cycle. Then:
  - go to IDLE;
  - timeout_out pulses;
  - match_cnt and locked_out clear;
  - period_out/high_out hold their last values.
- Rise and timeout condition in the same cycle:
  - timeout_out pulses;
  - no measurement is emitted;
  - match_cnt and locked_out clear;
  - state → ARMED, with cnt loaded to 1.
- A fall in IDLE is ignored.
- A period with no fall cannot occur after synchronization. high_out always reflects the most recent fall.

## Timing
- Reset values:
  - all outputs 0;
  - state IDLE;
  - synchronizer, prev, cnt, high_cap and match_cnt all 0.
- Reset asserts asynchronously and releases synchronously to clk_in through the normal flop path. Reset mid-measurement discards the partial period.
- Latency: sig_in first sampled high at clock edge k → meas_valid_out high during the cycle after edge k+2, i.e. 3 edges.
- Measurements are exact in clk_in cycles. Synchronizer jitter is ±1 cycle per edge for truly asynchronous inputs.
- locked_out rises in the same cycle as the meas_valid_out strobe that completes the LOCK_COUNT-th consecutive match. It falls in the same cycle as the mismatching strobe or timeout_out.
- Minimum resolvable high or low time: 1 cycle after synchronization. Shorter pulses may be lost and produce a single long period.

## Structure
- pwm_pkg holds:
  - typedef enum logic [1:0] {IDLE, ARMED, TRACK} cap_state_t;
  - the default period, tolerance and timeout constants shared with the transmit PWM.
- Sub-module sync_edge_det: 2-FF synchronizer plus prev register. Outputs level, rise and fall; reset is async active-low. It is reused by other external-input blocks.

## Test plan
- Reference square wave (period 2500, high 1250):
  - first meas_valid_out on the 2nd rise with period_out=2500, high_out=1250;
  - locked_out asserts on the 5th rise (4th measurement).
- Off-frequency square wave (period 2700, high 1350): measurements 2700/1350 every period, locked_out never asserts.
- Tolerance boundary:
  - periods alternating 2625 and 2375 → lock after 4 measurements;
  - one 2626 period → locked_out drops on that strobe;
  - relock after 4 further in-tolerance periods.
- Signal loss: lock at 2500, then hold sig_in low → timeout_out pulses exactly 5000 cycles after the cnt-load of the last rise; locked_out=0, state IDLE, period_out holds 2500.
- Rise coincident with timeout (edges exactly 5000 apart): timeout_out pulses, no meas_valid_out; the next rise 2500 later gives period_out=2500.
- Assert rst_n_in low mid-period while locked:
  - all outputs 0 immediately, asynchronously;
  - after release, the first measurement appears only on the 2nd new rise.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared PWM definitions: capture state encoding and default timing constants
// common to the transmit and receive paths.
package pwm_pkg;

    typedef enum logic [1:0] {IDLE, ARMED, TRACK} cap_state_t;

    localparam int unsigned PWM_PERIOD_CYCLES  = 2500;
    localparam int unsigned PWM_TOLERANCE      = 125;
    localparam int unsigned PWM_LOCK_COUNT     = 4;
    localparam int unsigned PWM_TIMEOUT_CYCLES = 5000;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for an asynchronous input, followed by a previous-value
// register that yields single-cycle rise and fall pulses.
module sync_edge_det (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level_o = sync_q;
    assign rise_o  = sync_q & ~prev_q;
    assign fall_o  = ~sync_q & prev_q;

endmodule

// File: rtl/pwm_capture.sv
// Measures period and high time of a synchronised square wave, tracks frequency
// lock against the expected period and flags loss of signal.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int unsigned PERIOD_IN_CLOCK_CYCLES = PWM_PERIOD_CYCLES,
    parameter int unsigned TOLERANCE              = PWM_TOLERANCE,
    parameter int unsigned LOCK_COUNT             = PWM_LOCK_COUNT,
    parameter int unsigned TIMEOUT_CYCLES         = PWM_TIMEOUT_CYCLES,
    parameter int unsigned W                      = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic         clk_in,
    input  logic         rst_n_in,
    input  logic         sig_in,
    output logic [W-1:0] period_out,
    output logic [W-1:0] high_out,
    output logic         meas_valid_out,
    output logic         locked_out,
    output logic         timeout_out
);

    localparam int unsigned        MW       = $clog2(LOCK_COUNT + 1);
    localparam logic [W-1:0]       CNT_MAX  = W'(TIMEOUT_CYCLES);
    localparam logic [MW-1:0]      LOCK_MAX = MW'(LOCK_COUNT);
    localparam logic signed [W:0]  PERIOD_S = (W+1)'(PERIOD_IN_CLOCK_CYCLES);
    localparam logic [W:0]         TOL_U    = (W+1)'(TOLERANCE);

    logic rise;
    logic fall;

    sync_edge_det u_sync (
        .clk_i   (clk_in),
        .rst_ni  (rst_n_in),
        .d_i     (sig_in),
        .level_o (),
        .rise_o  (rise),
        .fall_o  (fall)
    );

    cap_state_t     state_q, state_d;
    logic [W-1:0]   cnt_q, cnt_d;
    logic [W-1:0]   high_cap_q, high_cap_d;
    logic [W-1:0]   period_q, period_d;
    logic [W-1:0]   high_q, high_d;
    logic [MW-1:0]  match_q, match_d;
    logic           valid_q, valid_d;
    logic           locked_q, locked_d;
    logic           tmo_q, tmo_d;

    logic signed [W:0] diff;
    logic signed [W:0] mag;
    logic              in_tol;

    // One extra bit keeps the signed distance from the expected period exact.
    assign diff   = $signed({1'b0, cnt_q}) - PERIOD_S;
    assign mag    = diff[W] ? -diff : diff;
    assign in_tol = $unsigned(mag) <= TOL_U;

    always_comb begin
        state_d    = state_q;
        cnt_d      = rise ? W'(1) : ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + W'(1));
        high_cap_d = high_cap_q;
        period_d   = period_q;
        high_d     = high_q;
        match_d    = match_q;
        valid_d    = 1'b0;
        locked_d   = locked_q;
        tmo_d      = 1'b0;

        if (fall && state_q != IDLE) begin
            high_cap_d = cnt_q;
        end

        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = ARMED;
                end
            end
            ARMED, TRACK: begin
                if (cnt_q == CNT_MAX) begin
                    // A rise landing on the timeout re-arms instead of measuring.
                    tmo_d    = 1'b1;
                    match_d  = '0;
                    locked_d = 1'b0;
                    state_d  = rise ? ARMED : IDLE;
                end else if (rise) begin
                    state_d  = TRACK;
                    period_d = cnt_q;
                    high_d   = high_cap_q;
                    valid_d  = 1'b1;
                    if (in_tol) begin
                        match_d = (match_q == LOCK_MAX) ? match_q : match_q + MW'(1);
                    end else begin
                        match_d = '0;
                    end
                    locked_d = (match_d == LOCK_MAX);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            high_cap_q <= '0;
            period_q   <= '0;
            high_q     <= '0;
            match_q    <= '0;
            valid_q    <= 1'b0;
            locked_q   <= 1'b0;
            tmo_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            high_cap_q <= high_cap_d;
            period_q   <= period_d;
            high_q     <= high_d;
            match_q    <= match_d;
            valid_q    <= valid_d;
            locked_q   <= locked_d;
            tmo_q      <= tmo_d;
        end
    end

    assign period_out     = period_q;
    assign high_out       = high_q;
    assign meas_valid_out = valid_q;
    assign locked_out     = locked_q;
    assign timeout_out    = tmo_q;

endmodule
